// File: rtl/pushbutton_processor.sv
`default_nettype none
// ============================================================================
//  Module      : pushbutton_processor
//  Description : Synchronises and debounces one mechanical pushbutton sampled
//                on a 1 kHz clock. Each press is classified as short (one
//                count_up pulse on release) or long (one count_down pulse once
//                the hold reaches LONG_PRESS_MS).
//  Revision    : 1.0 - initial release
// ============================================================================
module pushbutton_processor #(
   parameter int DEBOUNCE_MS   = 20,
   parameter int LONG_PRESS_MS = 2000
) (
   input  logic clk_1khz,
   input  logic rst_i,
   input  logic pushbutton_i,
   output logic count_up,
   output logic count_down
);

   localparam int c_db_w       = $clog2(DEBOUNCE_MS + 1);
   localparam int c_hold_w_min = $clog2(LONG_PRESS_MS + 1);
   localparam int c_hold_w     = (c_hold_w_min < 11) ? 11 : c_hold_w_min;

   // Last count value before the debounced state may change.
   localparam logic [c_db_w-1:0]   c_db_last  = c_db_w'(DEBOUNCE_MS - 1);
   localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(LONG_PRESS_MS);

   logic                sync1_q;
   logic                sync_q;
   logic                deb_q;
   logic                deb_d;
   logic                deb_prev_q;
   logic [c_db_w-1:0]   db_cnt_q;
   logic [c_db_w-1:0]   db_cnt_d;
   logic [c_hold_w-1:0] hold_q;
   logic [c_hold_w-1:0] hold_d;
   logic                long_q;
   logic                long_d;
   logic                up_q;
   logic                up_d;
   logic                down_q;
   logic                down_d;

   logic                w_rise;
   logic                w_fall;
   logic                w_fire_down;

   // Debounce: the new level must be seen DEBOUNCE_MS samples in a row.
   always_comb begin
      deb_d    = deb_q;
      db_cnt_d = '0;
      if (sync_q != deb_q) begin
         if (db_cnt_q == c_db_last) begin
            deb_d = sync_q;
         end else begin
            db_cnt_d = db_cnt_q + c_db_w'(1);
         end
      end
   end

   assign w_rise      = deb_d & ~deb_q;
   assign w_fall      = deb_prev_q & ~deb_q;
   // Hold count has reached the threshold and this press has not fired yet.
   // Not gated by the debounced level so a press held for exactly
   // LONG_PRESS_MS cycles still classifies as long.
   assign w_fire_down = (hold_q == c_hold_max) & ~long_q;

   // Hold timing and press classification.
   always_comb begin
      hold_d = hold_q;
      long_d = long_q;
      if (w_fire_down) begin
         long_d = 1'b1;
      end
      if (w_rise) begin
         hold_d = '0;
         long_d = 1'b0;
      end else if (deb_q && (hold_q != c_hold_max)) begin
         hold_d = hold_q + c_hold_w'(1);
      end
      down_d = w_fire_down;
      // A release on the same cycle the long pulse fires belongs to the long press.
      up_d   = w_fall & ~long_q & ~w_fire_down;
   end

   // State registers; reset overrides everything.
   always_ff @(posedge clk_1khz) begin
      if (rst_i) begin
         sync1_q    <= 1'b0;
         sync_q     <= 1'b0;
         deb_q      <= 1'b0;
         deb_prev_q <= 1'b0;
         db_cnt_q   <= '0;
         hold_q     <= '0;
         long_q     <= 1'b0;
         up_q       <= 1'b0;
         down_q     <= 1'b0;
      end else begin
         sync1_q    <= pushbutton_i;
         sync_q     <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         db_cnt_q   <= db_cnt_d;
         hold_q     <= hold_d;
         long_q     <= long_d;
         up_q       <= up_d;
         down_q     <= down_d;
      end
   end

   assign count_up   = up_q;
   assign count_down = down_q;

endmodule
`default_nettype wire

// File: tb/tb_pushbutton_processor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pushbutton_processor
//  Description : Self-checking bench for pushbutton_processor. A reference
//                model predicts every pulse and its cycle; a monitor compares
//                the outputs against that queue every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pushbutton_processor;

   localparam int DB = 20;
   localparam int LP = 2000;

   typedef struct {
      bit is_down;
      int due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pin = 1'b0;
   logic up;
   logic down;

   exp_t q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   fails  = 0;
   int   n_up   = 0;
   int   n_down = 0;

   pushbutton_processor #(
      .DEBOUNCE_MS   (DB),
      .LONG_PRESS_MS (LP)
   ) dut (
      .clk_1khz     (clk),
      .rst_i        (rst),
      .pushbutton_i (pin),
      .count_up     (up),
      .count_down   (down)
   );

   always #5 clk = ~clk;

   // Reference model: run-length view of the pin, press length in cycles.
   initial begin : model
      bit h1, h2, v, run_lvl, deb, deb_old, lng;
      int run_len, hc;
      h1 = 0; h2 = 0; run_lvl = 0; deb = 0; lng = 0; run_len = 0; hc = 0;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            h1 = 0; h2 = 0; run_lvl = 0; run_len = 0;
            deb = 0; hc = 0; lng = 0;
            q.delete();
         end else begin
            // Level seen by the debouncer is the pin two samples ago.
            v  = h2;
            h2 = h1;
            h1 = pin;
            if (v == run_lvl) run_len++;
            else begin
               run_lvl = v;
               run_len = 1;
            end
            deb_old = deb;
            if (run_len == DB && v != deb) deb = v;
            if (deb_old) begin
               if (hc < LP) hc++;
               if (hc == LP && !lng) begin
                  lng = 1;
                  q.push_back('{1'b1, cyc + 1});
               end
            end
            if (!deb_old && deb) begin
               hc  = 0;
               lng = 0;
            end
            if (deb_old && !deb && !lng) q.push_back('{1'b0, cyc + 1});
         end
      end
   end

   // Monitor: every cycle the outputs must equal what the queue predicts.
   initial begin : monitor
      bit exp_up, exp_dn;
      forever begin
         @(negedge clk);
         exp_up = 0;
         exp_dn = 0;
         if (q.size() > 0 && q[0].due == cyc) begin
            if (q[0].is_down) exp_dn = 1;
            else              exp_up = 1;
            void'(q.pop_front());
         end
         checks++;
         if (up !== exp_up || down !== exp_dn) begin
            fails++;
            $display("FAIL pulse cyc=%0d: got up=%b down=%b, expected up=%b down=%b",
                     cyc, up, down, exp_up, exp_dn);
         end
         if (up === 1'b1)   n_up++;
         if (down === 1'b1) n_down++;
      end
   end

   initial begin : watchdog
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input logic p, input logic r);
      @(posedge clk);
      #1;
      pin = p;
      rst = r;
   endtask

   task automatic run(input logic p, input int n);
      repeat (n) step(p, 1'b0);
   endtask

   // Toggle the pin with 1-2 ms intervals, starting high.
   task automatic bounce(input int total);
      int  rem = total;
      bit  l   = 1'b1;
      while (rem > 0) begin
         int len = $urandom_range(1, 2);
         if (len > rem) len = rem;
         run(l, len);
         rem -= len;
         l = ~l;
      end
   endtask

   task automatic phase_check(input string name, input int eu, input int ed,
                              input int u0, input int d0);
      checks++;
      if ((n_up - u0) != eu || (n_down - d0) != ed) begin
         fails++;
         $display("FAIL %s: got up pulses=%0d down pulses=%0d, expected up=%0d down=%0d",
                  name, n_up - u0, n_down - d0, eu, ed);
      end
   endtask

   initial begin : stim
      int u0, d0, len;

      u0 = n_up; d0 = n_down;
      repeat (5) step(1'($urandom), 1'b1);
      run(1'b0, 50);
      phase_check("reset", 0, 0, u0, d0);

      u0 = n_up; d0 = n_down;
      bounce(10);
      run(1'b0, 60);
      phase_check("bounce_filter", 0, 0, u0, d0);

      u0 = n_up; d0 = n_down;
      bounce(8);
      run(1'b1, 30);
      run(1'b0, 60);
      phase_check("short_press", 1, 0, u0, d0);

      u0 = n_up; d0 = n_down;
      run(1'b1, 2130);
      bounce(7);
      run(1'b0, 60);
      phase_check("long_press", 0, 1, u0, d0);

      u0 = n_up; d0 = n_down;
      run(1'b1, 1999);
      run(1'b0, 60);
      phase_check("hold_1999", 1, 0, u0, d0);

      u0 = n_up; d0 = n_down;
      run(1'b1, 2000);
      run(1'b0, 60);
      phase_check("hold_2000", 0, 1, u0, d0);

      u0 = n_up; d0 = n_down;
      run(1'b1, 1000);
      step(1'b1, 1'b1);
      run(1'b1, 2100);
      run(1'b0, 60);
      phase_check("reset_mid_press", 0, 1, u0, d0);

      // Random presses: durations clustered near the threshold and spread
      // widely, with bounce and occasional resets.
      repeat (12) begin
         if ($urandom_range(0, 2) == 0) len = $urandom_range(1990, 2010);
         else                           len = $urandom_range(1, 2200);
         bounce($urandom_range(0, 10));
         if ($urandom_range(0, 5) == 0) begin
            run(1'b1, len / 2);
            step(1'b1, 1'b1);
            run(1'b1, len - len / 2);
         end else begin
            run(1'b1, len);
         end
         bounce($urandom_range(0, 10));
         run(1'b0, $urandom_range(25, 80));
      end

      run(1'b0, 100);
      checks++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL queue_drained: got %0d pending pulses, expected 0", q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
